// File: rtl/mem_store_buffer.sv
// MEM-stage access controller: posts stores into a small FIFO store buffer
// that drains one word per cycle into a single-port data memory, serves loads
// combinationally with byte/halfword extraction, and raises stall on
// buffer-full and load-after-store hazards.
module mem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        misalign,
  output logic        sb_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Byte-enable mask of a store within its word.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store data replicated so that every enabled lane carries the right bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Read-modify-write merge: masked lanes from the entry, the rest from memory.
  function automatic logic [31:0] merge_lanes(input logic [3:0] mask, input logic [31:0] new_word,
                                              input logic [31:0] old_word);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = mask[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return r;
  endfunction

  // Alignment rule: halves need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lane[0];
      default: ok = (lane == 2'b00);
    endcase
    return ok;
  endfunction

  // Byte/halfword extraction with sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                               input logic uns, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  logic [29:0]   idx_r   [DEPTH];
  logic [31:0]   data_r  [DEPTH];
  logic [3:0]    mask_r  [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW:0]   count_r;

  logic aligned_s;
  logic hit_s;
  logic load_go_s;
  logic store_ok_s;
  logic drain_s;
  logic enq_s;

  // Request decode, hazard detection, port arbitration and load extraction.
  always_comb begin
    aligned_s    = is_aligned(ex_size, ex_addr[1:0]);
    hit_s        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (valid_r[i] & (idx_r[i] == ex_addr[31:2]));
    end
    load_go_s    = ~rst & ex_mem_read & aligned_s & ~hit_s;
    store_ok_s   = ~rst & ex_mem_write & aligned_s;
    drain_s      = ~rst & ~load_go_s & (count_r != '0);
    enq_s        = store_ok_s & (count_r != FULL_COUNT);

    misalign     = ~rst & (ex_mem_read | ex_mem_write) & ~aligned_s;
    stall        = (~rst & ex_mem_read & aligned_s & hit_s) | (store_ok_s & (count_r == FULL_COUNT));
    sb_empty     = rst | (count_r == '0);
    dm_mem_read  = load_go_s;
    dm_mem_write = drain_s;
    load_valid   = load_go_s;
    dm_addr      = 32'h0000_0000;
    dm_wdata     = 32'h0000_0000;
    load_data    = 32'h0000_0000;
    if (load_go_s) begin
      dm_addr   = {2'b00, ex_addr[31:2]};
      load_data = load_extract(ex_size, ex_addr[1:0], ex_unsigned, dm_rdata);
    end else if (drain_s) begin
      dm_addr  = {2'b00, idx_r[head_r]};
      dm_wdata = merge_lanes(mask_r[head_r], data_r[head_r], dm_rdata);
    end else begin
      dm_addr  = 32'h0000_0000;
      dm_wdata = 32'h0000_0000;
    end
  end

  // FIFO state: pop on drain, push on accepted store, count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_r[i]  <= 30'h0000_0000;
        data_r[i] <= 32'h0000_0000;
        mask_r[i] <= 4'b0000;
      end
    end else begin
      if (drain_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + 1'b1;
      end
      if (enq_s) begin
        valid_r[tail_r] <= 1'b1;
        idx_r[tail_r]   <= ex_addr[31:2];
        data_r[tail_r]  <= store_lanes(ex_size, ex_wdata);
        mask_r[tail_r]  <= store_mask(ex_size, ex_addr[1:0]);
        tail_r          <= tail_r + 1'b1;
      end
      count_r <= count_r + (AW+1)'(enq_s) - (AW+1)'(drain_s);
    end
  end

endmodule
